// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator / checker pair: FSM states and
// the parity-sense encoding both sides agree on.
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam bit PAR_EVEN = 1'b0;
   localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker.sv
// Reassembles LSB-first serial frames (DATA_W data bits + parity bit), checks
// parity, and keeps a saturating count of parity errors and aborted frames.
module serial_parity_checker
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W     = 3,
   parameter bit          ODD_PARITY = PAR_EVEN,
   parameter int unsigned CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic              in_bit,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_parity_err,
   output logic              frame_abort,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              busy
);

   localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = (DATA_W > 1) ? IDX_W'(1) : '0;

   state_t             state;
   logic [IDX_W-1:0]   bit_idx;
   logic [DATA_W-1:0]  shreg;
   logic               acc;
   logic               frame_err;
   logic               cnt_inc;

   // Abort and parity-error events are mutually exclusive in a cycle, so one
   // increment per edge is sufficient.
   always_comb begin
      frame_err = acc ^ in_bit ^ ODD_PARITY;
      cnt_inc   = 1'b0;
      if (in_valid && state != IDLE) begin
         if (in_sof)
            cnt_inc = 1'b1;
         else if (state == PARITY)
            cnt_inc = frame_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bit_idx        <= '0;
         shreg          <= '0;
         acc            <= 1'b0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_parity_err <= 1'b0;
         frame_abort    <= 1'b0;
         err_cnt        <= '0;
      end else begin
         out_valid   <= 1'b0;
         frame_abort <= 1'b0;

         if (cnt_inc && err_cnt != '1)
            err_cnt <= err_cnt + CNT_W'(1);

         if (in_valid) begin
            if (in_sof) begin
               // A start bit always opens a new frame; mid-frame it also drops the old one.
               frame_abort <= (state != IDLE);
               shreg       <= '0;
               shreg[0]    <= in_bit;
               acc         <= in_bit;
               bit_idx     <= IDX_ONE;
               state       <= (DATA_W == 1) ? PARITY : DATA;
            end else begin
               case (state)
                  DATA: begin
                     shreg[bit_idx] <= in_bit;
                     acc            <= acc ^ in_bit;
                     if (bit_idx == LAST_IDX)
                        state <= PARITY;
                     else
                        bit_idx <= bit_idx + IDX_W'(1);
                  end
                  PARITY: begin
                     out_data       <= shreg;
                     out_parity_err <= frame_err;
                     out_valid      <= 1'b1;
                     state          <= IDLE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: even, odd and narrow-counter
// instances share one serial stream; each section checks the relevant one.
module tb_serial_parity_checker;
   import parity_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_sof = 1'b0;
   logic in_bit = 1'b0;

   logic       e_valid, e_perr, e_abort, e_busy;
   logic [2:0] e_data;
   logic [7:0] e_cnt;
   logic       o_valid, o_perr, o_abort, o_busy;
   logic [2:0] o_data;
   logic [7:0] o_cnt;
   logic       s_valid, s_perr, s_abort, s_busy;
   logic [2:0] s_data;
   logic [1:0] s_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_parity_checker #(.DATA_W(3), .ODD_PARITY(PAR_EVEN), .CNT_W(8)) u_even (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
      .out_valid(e_valid), .out_data(e_data), .out_parity_err(e_perr),
      .frame_abort(e_abort), .err_cnt(e_cnt), .busy(e_busy));

   serial_parity_checker #(.DATA_W(3), .ODD_PARITY(PAR_ODD), .CNT_W(8)) u_odd (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
      .out_valid(o_valid), .out_data(o_data), .out_parity_err(o_perr),
      .frame_abort(o_abort), .err_cnt(o_cnt), .busy(o_busy));

   serial_parity_checker #(.DATA_W(3), .ODD_PARITY(PAR_EVEN), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
      .out_valid(s_valid), .out_data(s_data), .out_parity_err(s_perr),
      .frame_abort(s_abort), .err_cnt(s_cnt), .busy(s_busy));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one bit for one cycle; returns 1 time unit after the accepting edge.
   task automatic send_bit(input logic sof, input logic b);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof;
      in_bit   = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [2:0] w, input logic p, input int max_gap);
      for (int i = 0; i < 3; i++) begin
         send_bit(i == 0, w[i]);
         if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
      end
      send_bit(1'b0, p);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] even_par;
      logic [1:0] sat_exp [5];
      even_par = 8'b1001_0110;  // even-parity bit for words 7..0
      sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // Reset state
      idle(2);
      check_eq("rst_valid", e_valid, 0);
      check_eq("rst_data",  e_data,  0);
      check_eq("rst_perr",  e_perr,  0);
      check_eq("rst_abort", e_abort, 0);
      check_eq("rst_cnt",   e_cnt,   0);
      check_eq("rst_busy",  e_busy,  0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // Basic even frame, good then bad parity
      send_frame(3'b101, 1'b0, 0);
      check_eq("even_ok_valid", e_valid, 1);
      check_eq("even_ok_data",  e_data,  3'b101);
      check_eq("even_ok_perr",  e_perr,  0);
      check_eq("even_ok_cnt",   e_cnt,   0);
      idle(1);
      check_eq("even_pulse",    e_valid, 0);
      check_eq("even_hold",     e_data,  3'b101);
      send_frame(3'b101, 1'b1, 0);
      check_eq("even_bad_valid", e_valid, 1);
      check_eq("even_bad_perr",  e_perr,  1);
      check_eq("even_bad_cnt",   e_cnt,   1);

      // Odd-parity instance
      do_reset();
      send_frame(3'b011, 1'b1, 0);
      check_eq("odd_valid", o_valid, 1);
      check_eq("odd_data",  o_data,  3'b011);
      check_eq("odd_perr",  o_perr,  0);
      check_eq("odd_cnt",   o_cnt,   0);

      // Exhaustive back-to-back words with generator parity
      do_reset();
      for (int w = 0; w < 8; w++) begin
         send_bit(1'b1, w[0]);
         check_eq("exh_busy", e_busy, 1);
         send_bit(1'b0, w[1]);
         send_bit(1'b0, w[2]);
         send_bit(1'b0, even_par[w]);
         check_eq("exh_valid", e_valid, 1);
         check_eq("exh_data",  e_data,  w[2:0]);
         check_eq("exh_perr",  e_perr,  0);
         check_eq("exh_odd_perr", o_perr, 1);
      end
      check_eq("exh_cnt",     e_cnt, 0);
      check_eq("exh_odd_cnt", o_cnt, 8);

      // Mid-frame restart
      do_reset();
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      check_eq("abort_pulse", e_abort, 1);
      check_eq("abort_noval", e_valid, 0);
      check_eq("abort_cnt",   e_cnt,   1);
      check_eq("abort_busy",  e_busy,  1);
      send_bit(1'b0, 1'b0);
      check_eq("abort_clear", e_abort, 0);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      check_eq("restart_valid", e_valid, 1);
      check_eq("restart_data",  e_data,  3'b100);
      check_eq("restart_perr",  e_perr,  0);
      check_eq("restart_cnt",   e_cnt,   1);

      // Stray bits while idle, then a frame with random gaps
      do_reset();
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
      check_eq("stray_busy",  e_busy,  0);
      check_eq("stray_valid", e_valid, 0);
      check_eq("stray_cnt",   e_cnt,   0);
      send_frame(3'b110, 1'b0, 4);
      check_eq("gap_valid", e_valid, 1);
      check_eq("gap_data",  e_data,  3'b110);
      check_eq("gap_perr",  e_perr,  0);
      check_eq("gap_cnt",   e_cnt,   0);

      // Asynchronous reset mid-frame
      send_frame(3'b111, 1'b0, 0);
      check_eq("pre_rst_perr", e_perr, 1);
      check_eq("pre_rst_cnt",  e_cnt,  1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_data", e_data, 0);
      check_eq("arst_perr", e_perr, 0);
      check_eq("arst_cnt",  e_cnt,  0);
      check_eq("arst_busy", e_busy, 0);
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check_eq("arst_noval",   e_valid, 0);
      check_eq("arst_noabort", e_abort, 0);
      send_frame(3'b010, 1'b1, 0);
      check_eq("post_rst_valid", e_valid, 1);
      check_eq("post_rst_data",  e_data,  3'b010);
      check_eq("post_rst_perr",  e_perr,  0);

      // Counter saturation on the 2-bit instance
      do_reset();
      for (int k = 0; k < 5; k++) begin
         send_frame(3'b001, 1'b0, 0);
         check_eq("sat_perr", s_perr, 1);
         check_eq("sat_cnt",  s_cnt,  sat_exp[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
